// File: rtl/lsu_if.sv
// Memory-side bus of the load/store unit: one read channel and one write channel.
// Handshake: valid, address and data stay stable from assertion until ready is seen high at a clock edge; valid then drops.
interface lsu_if #(
    parameter int DATA_BITS = 8,
    parameter int ADDR_BITS = 8
);
    logic                 mem_read_valid;
    logic [ADDR_BITS-1:0] mem_read_address;
    logic                 mem_read_ready;
    logic [DATA_BITS-1:0] mem_read_data;
    logic                 mem_write_valid;
    logic [ADDR_BITS-1:0] mem_write_address;
    logic [DATA_BITS-1:0] mem_write_data;
    logic                 mem_write_ready;

    modport master (
        output mem_read_valid, mem_read_address,
        input  mem_read_ready, mem_read_data,
        output mem_write_valid, mem_write_address, mem_write_data,
        input  mem_write_ready
    );

    modport slave (
        input  mem_read_valid, mem_read_address,
        output mem_read_ready, mem_read_data,
        input  mem_write_valid, mem_write_address, mem_write_data,
        output mem_write_ready
    );
endinterface

// File: rtl/lsu.sv
// Per-thread load/store unit issuing scalar or VECTOR_SIZE-element memory accesses.
// Optional WAITING timeout with lsu_error is enabled by defining LSU_TIMEOUT_EN.
module lsu #(
    parameter int DATA_BITS      = 8,
    parameter int ADDR_BITS      = 8,
    parameter int VECTOR_SIZE    = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             enable,
    input  logic [2:0]                       core_state,
    input  logic                             decoded_mem_read_enable,
    input  logic                             decoded_mem_write_enable,
    input  logic                             decoded_vector_mux,
    input  logic [DATA_BITS-1:0]             rs,
    input  logic [DATA_BITS-1:0]             rt,
    input  logic [VECTOR_SIZE*DATA_BITS-1:0] v_rt,
    lsu_if.master                            mem,
    output logic [1:0]                       lsu_state,
    output logic [DATA_BITS-1:0]             lsu_out,
    output logic [VECTOR_SIZE*DATA_BITS-1:0] v_lsu_out,
    output logic                             lsu_error
);
    localparam logic [2:0] CORE_REQUEST = 3'b011;
    localparam logic [2:0] CORE_UPDATE  = 3'b110;
    localparam int IDX_W  = (VECTOR_SIZE > 1) ? $clog2(VECTOR_SIZE) : 1;
    localparam int EXT_W  = (DATA_BITS > ADDR_BITS) ? DATA_BITS : ADDR_BITS;

    typedef enum logic [1:0] {
        S_IDLE       = 2'b00,
        S_REQUESTING = 2'b01,
        S_WAITING    = 2'b10,
        S_DONE       = 2'b11
    } state_t;

    state_t                           state_q, state_d;
    logic [IDX_W-1:0]                 idx_q, idx_d;
    logic                             is_read_q, is_read_d;
    logic                             is_vec_q, is_vec_d;
    logic                             rd_valid_q, rd_valid_d;
    logic [ADDR_BITS-1:0]             rd_addr_q, rd_addr_d;
    logic                             wr_valid_q, wr_valid_d;
    logic [ADDR_BITS-1:0]             wr_addr_q, wr_addr_d;
    logic [DATA_BITS-1:0]             wr_data_q, wr_data_d;
    logic [DATA_BITS-1:0]             lsu_out_q, lsu_out_d;
    logic [VECTOR_SIZE*DATA_BITS-1:0] v_lsu_out_q, v_lsu_out_d;
    logic                             err_q, err_d;

    logic [EXT_W-1:0]     rs_ext;
    logic [ADDR_BITS-1:0] req_addr;
    logic                 act_ready;
    logic                 last_elem;

    // rs is zero-extended when narrower than the address; the sum wraps silently.
    assign rs_ext    = EXT_W'(rs);
    assign req_addr  = rs_ext[ADDR_BITS-1:0] + ADDR_BITS'(idx_q);
    assign act_ready = is_read_q ? mem.mem_read_ready : mem.mem_write_ready;
    assign last_elem = !is_vec_q || (idx_q == IDX_W'(VECTOR_SIZE - 1));

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        is_read_d   = is_read_q;
        is_vec_d    = is_vec_q;
        rd_valid_d  = rd_valid_q;
        rd_addr_d   = rd_addr_q;
        wr_valid_d  = wr_valid_q;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        lsu_out_d   = lsu_out_q;
        v_lsu_out_d = v_lsu_out_q;
        err_d       = err_q;
`ifdef LSU_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif
        if (enable) begin
            case (state_q)
                S_IDLE: begin
                    if (core_state == CORE_REQUEST &&
                        (decoded_mem_read_enable || decoded_mem_write_enable)) begin
                        state_d   = S_REQUESTING;
                        idx_d     = '0;
                        is_read_d = decoded_mem_read_enable;
                        is_vec_d  = decoded_vector_mux;
                    end
                end
                S_REQUESTING: begin
                    state_d = S_WAITING;
`ifdef LSU_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                    if (is_read_q) begin
                        rd_valid_d = 1'b1;
                        rd_addr_d  = req_addr;
                    end else begin
                        wr_valid_d = 1'b1;
                        wr_addr_d  = req_addr;
                        wr_data_d  = is_vec_q ? v_rt[32'(idx_q)*DATA_BITS +: DATA_BITS] : rt;
                    end
                end
                S_WAITING: begin
                    if (act_ready) begin
                        rd_valid_d = 1'b0;
                        wr_valid_d = 1'b0;
                        if (is_read_q) begin
                            if (is_vec_q)
                                v_lsu_out_d[32'(idx_q)*DATA_BITS +: DATA_BITS] = mem.mem_read_data;
                            else
                                lsu_out_d = mem.mem_read_data;
                        end
                        if (last_elem) begin
                            state_d = S_DONE;
                        end else begin
                            idx_d   = idx_q + 1'b1;
                            state_d = S_REQUESTING;
                        end
                    end
`ifdef LSU_TIMEOUT_EN
                    // The final waiting cycle is the one whose count is TIMEOUT_CYCLES-1.
                    else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        rd_valid_d = 1'b0;
                        wr_valid_d = 1'b0;
                        err_d      = 1'b1;
                        state_d    = S_DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
`endif
                end
                S_DONE: begin
                    if (core_state == CORE_UPDATE) begin
                        state_d = S_IDLE;
                        err_d   = 1'b0;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            is_read_q   <= 1'b0;
            is_vec_q    <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_addr_q   <= '0;
            wr_valid_q  <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            lsu_out_q   <= '0;
            v_lsu_out_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            is_read_q   <= is_read_d;
            is_vec_q    <= is_vec_d;
            rd_valid_q  <= rd_valid_d;
            rd_addr_q   <= rd_addr_d;
            wr_valid_q  <= wr_valid_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            lsu_out_q   <= lsu_out_d;
            v_lsu_out_q <= v_lsu_out_d;
            err_q       <= err_d;
        end
    end

`ifdef LSU_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
    assign lsu_error = err_q;
`else
    assign lsu_error = 1'b0;
`endif

    assign mem.mem_read_valid    = rd_valid_q;
    assign mem.mem_read_address  = rd_addr_q;
    assign mem.mem_write_valid   = wr_valid_q;
    assign mem.mem_write_address = wr_addr_q;
    assign mem.mem_write_data    = wr_data_q;
    assign lsu_state             = state_q;
    assign lsu_out               = lsu_out_q;
    assign v_lsu_out             = v_lsu_out_q;
endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: memory responder, address scoreboard and a behavioural result model.
module tb_lsu;
    localparam int DB = 8;
    localparam int AB = 8;
    localparam int VS = 4;
`ifdef LSU_TIMEOUT_EN
    localparam int TO = 4;
`else
    localparam int TO = 255;
`endif
    localparam logic [2:0] ST_IDLE    = 3'b000;
    localparam logic [2:0] ST_REQUEST = 3'b011;
    localparam logic [2:0] ST_WAIT    = 3'b100;
    localparam logic [2:0] ST_UPDATE  = 3'b110;

    logic              clk = 1'b0;
    logic              reset;
    logic              enable;
    logic [2:0]        core_state;
    logic              rd_en, wr_en, vec_en;
    logic [DB-1:0]     rs, rt;
    logic [VS*DB-1:0]  v_rt;
    logic [1:0]        lsu_state;
    logic [DB-1:0]     lsu_out;
    logic [VS*DB-1:0]  v_lsu_out;
    logic              lsu_error;

    lsu_if #(.DATA_BITS(DB), .ADDR_BITS(AB)) mem_bus ();

    lsu #(.DATA_BITS(DB), .ADDR_BITS(AB), .VECTOR_SIZE(VS), .TIMEOUT_CYCLES(TO)) dut (
        .clk                      (clk),
        .reset                    (reset),
        .enable                   (enable),
        .core_state               (core_state),
        .decoded_mem_read_enable  (rd_en),
        .decoded_mem_write_enable (wr_en),
        .decoded_vector_mux       (vec_en),
        .rs                       (rs),
        .rt                       (rt),
        .v_rt                     (v_rt),
        .mem                      (mem_bus),
        .lsu_state                (lsu_state),
        .lsu_out                  (lsu_out),
        .v_lsu_out                (v_lsu_out),
        .lsu_error                (lsu_error)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int tests_run    = 0;
    int tests_failed = 0;

    logic [DB-1:0] mem_model [256];
    logic [AB-1:0] exp_q [$];
    logic [DB-1:0] exp_lsu_out;
    logic [DB-1:0] exp_vec [VS];

    function automatic logic [VS*DB-1:0] exp_vec_packed();
        logic [VS*DB-1:0] r;
        for (int i = 0; i < VS; i++) r[i*DB +: DB] = exp_vec[i];
        return r;
    endfunction

    task automatic clear_inputs();
        core_state              = ST_IDLE;
        rd_en                   = 1'b0;
        wr_en                   = 1'b0;
        vec_en                  = 1'b0;
        mem_bus.mem_read_ready  = 1'b0;
        mem_bus.mem_write_ready = 1'b0;
        mem_bus.mem_read_data   = '0;
    endtask

    task automatic model_reset();
        exp_q.delete();
        exp_lsu_out = '0;
        for (int i = 0; i < VS; i++) exp_vec[i] = '0;
    endtask

    // Full access driven cycle by cycle; dly[e] < 0 picks a random ready delay.
    task automatic run_access(input logic r, input logic w, input logic v,
                              input logic [DB-1:0] base, input logic [DB-1:0] sdata,
                              input logic [VS*DB-1:0] vdata, input int dly[VS],
                              input bit freeze, input int abort_at);
        int n;
        int d;
        logic [AB-1:0] a;
        logic [DB-1:0] wd;
        logic act_valid, oth_valid;
        logic [AB-1:0] act_addr;
        n = v ? VS : 1;
        for (int e = 0; e < n; e++) exp_q.push_back(base + AB'(e));
        @(negedge clk);
        core_state = ST_REQUEST; rd_en = r; wr_en = w; vec_en = v;
        rs = base; rt = sdata; v_rt = vdata;
        @(negedge clk);
        core_state = ST_WAIT;
        for (int e = 0; e < n; e++) begin
            tests_run++;
            if (lsu_state !== 2'b01) begin
                tests_failed++;
                $display("FAIL req_state elem %0d: got %b want 01", e, lsu_state);
            end
            @(negedge clk);
            a  = exp_q.pop_front();
            wd = v ? vdata[e*DB +: DB] : sdata;
            act_valid = r ? mem_bus.mem_read_valid : mem_bus.mem_write_valid;
            oth_valid = r ? mem_bus.mem_write_valid : mem_bus.mem_read_valid;
            act_addr  = r ? mem_bus.mem_read_address : mem_bus.mem_write_address;
            tests_run++;
            if (lsu_state !== 2'b10 || act_valid !== 1'b1 || oth_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL issue elem %0d: state %b valid %b other %b want 10/1/0",
                         e, lsu_state, act_valid, oth_valid);
            end
            tests_run++;
            if (act_addr !== a) begin
                tests_failed++;
                $display("FAIL address elem %0d: got %h want %h", e, act_addr, a);
            end
            if (!r) begin
                tests_run++;
                if (mem_bus.mem_write_data !== wd) begin
                    tests_failed++;
                    $display("FAIL wdata elem %0d: got %h want %h", e, mem_bus.mem_write_data, wd);
                end
            end
            if (abort_at == e) begin
                #2 reset = 1'b1;
                #1;
                model_reset();
                tests_run++;
                if (mem_bus.mem_read_valid !== 1'b0 || mem_bus.mem_write_valid !== 1'b0 ||
                    lsu_state !== 2'b00) begin
                    tests_failed++;
                    $display("FAIL async_reset: rv %b wv %b state %b want 0/0/00",
                             mem_bus.mem_read_valid, mem_bus.mem_write_valid, lsu_state);
                end
                tests_run++;
                if (lsu_out !== exp_lsu_out || v_lsu_out !== exp_vec_packed()) begin
                    tests_failed++;
                    $display("FAIL async_reset_data: lsu_out %h v %h want 0", lsu_out, v_lsu_out);
                end
                @(negedge clk);
                reset = 1'b0;
                clear_inputs();
                return;
            end
            if (freeze && e == 0) begin
                enable = 1'b0;
                mem_bus.mem_read_ready = 1'b1; mem_bus.mem_write_ready = 1'b1;
                mem_bus.mem_read_data = DB'($urandom);
                @(negedge clk);
                act_valid = r ? mem_bus.mem_read_valid : mem_bus.mem_write_valid;
                tests_run++;
                if (act_valid !== 1'b1 || lsu_state !== 2'b10) begin
                    tests_failed++;
                    $display("FAIL freeze: valid %b state %b want 1/10", act_valid, lsu_state);
                end
                enable = 1'b1;
                mem_bus.mem_read_ready = 1'b0; mem_bus.mem_write_ready = 1'b0;
            end
            d = (dly[e] < 0) ? int'($urandom_range(0, 3)) : dly[e];
            for (int k = 0; k < d; k++) begin
                if (r) mem_bus.mem_write_ready = 1'($urandom);
                else   mem_bus.mem_read_ready  = 1'($urandom);
                mem_bus.mem_read_data = DB'($urandom);
                @(negedge clk);
                act_valid = r ? mem_bus.mem_read_valid : mem_bus.mem_write_valid;
                act_addr  = r ? mem_bus.mem_read_address : mem_bus.mem_write_address;
                tests_run++;
                if (act_valid !== 1'b1 || act_addr !== a || lsu_state !== 2'b10) begin
                    tests_failed++;
                    $display("FAIL hold elem %0d: valid %b addr %h state %b want 1/%h/10",
                             e, act_valid, act_addr, lsu_state, a);
                end
            end
            if (r) begin
                mem_bus.mem_read_ready  = 1'b1;
                mem_bus.mem_write_ready = 1'b0;
                mem_bus.mem_read_data   = mem_model[a];
            end else begin
                mem_bus.mem_write_ready = 1'b1;
                mem_bus.mem_read_ready  = 1'b0;
            end
            @(negedge clk);
            mem_bus.mem_read_ready = 1'b0; mem_bus.mem_write_ready = 1'b0;
            mem_bus.mem_read_data  = DB'($urandom);
            if (r) begin
                if (v) exp_vec[e] = mem_model[a];
                else   exp_lsu_out = mem_model[a];
            end else begin
                mem_model[a] = wd;
            end
            tests_run++;
            if (mem_bus.mem_read_valid !== 1'b0 || mem_bus.mem_write_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL release elem %0d: rv %b wv %b want 0/0",
                         e, mem_bus.mem_read_valid, mem_bus.mem_write_valid);
            end
        end
        tests_run++;
        if (lsu_state !== 2'b11) begin
            tests_failed++;
            $display("FAIL done_state: got %b want 11", lsu_state);
        end
        @(negedge clk);
        tests_run++;
        if (lsu_state !== 2'b11) begin
            tests_failed++;
            $display("FAIL done_hold: got %b want 11", lsu_state);
        end
        core_state = ST_UPDATE;
        @(negedge clk);
        tests_run++;
        if (lsu_state !== 2'b00) begin
            tests_failed++;
            $display("FAIL update_idle: got %b want 00", lsu_state);
        end
        clear_inputs();
        tests_run++;
        if (lsu_out !== exp_lsu_out || v_lsu_out !== exp_vec_packed() || lsu_error !== 1'b0) begin
            tests_failed++;
            $display("FAIL results: lsu_out %h v %h err %b want %h %h 0",
                     lsu_out, v_lsu_out, lsu_error, exp_lsu_out, exp_vec_packed());
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b1; rs = '0; rt = '0; v_rt = '0;
        clear_inputs();
        model_reset();
        repeat (3) @(negedge clk);
        tests_run++;
        if (lsu_state !== 2'b00 || mem_bus.mem_read_valid !== 1'b0 || mem_bus.mem_write_valid !== 1'b0 ||
            mem_bus.mem_read_address !== '0 || mem_bus.mem_write_address !== '0 ||
            mem_bus.mem_write_data !== '0 || lsu_out !== '0 || v_lsu_out !== '0 || lsu_error !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_values: state %b rv %b wv %b ra %h wa %h wd %h out %h v %h err %b want all 0",
                     lsu_state, mem_bus.mem_read_valid, mem_bus.mem_write_valid, mem_bus.mem_read_address,
                     mem_bus.mem_write_address, mem_bus.mem_write_data, lsu_out, v_lsu_out, lsu_error);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_scalar_load();
        int dly[VS];
        dly = '{1, 0, 0, 0};
        mem_model[8'h10] = 8'hA5;
        run_access(1'b1, 1'b0, 1'b0, 8'h10, 8'h00, '0, dly, 1'b0, -1);
        tests_run++;
        if (lsu_out !== 8'hA5) begin
            tests_failed++;
            $display("FAIL scalar_load: got %h want a5", lsu_out);
        end
    endtask

    task automatic test_scalar_store();
        int dly[VS];
        dly = '{2, 0, 0, 0};
        run_access(1'b0, 1'b1, 1'b0, 8'h20, 8'h3C, '0, dly, 1'b0, -1);
    endtask

    task automatic test_vector_load();
        int dly[VS];
        dly = '{0, 2, 1, 3};
        mem_model[8'hFE] = 8'h11; mem_model[8'hFF] = 8'h22;
        mem_model[8'h00] = 8'h33; mem_model[8'h01] = 8'h44;
        run_access(1'b1, 1'b0, 1'b1, 8'hFE, 8'h00, '0, dly, 1'b0, -1);
        tests_run++;
        if (v_lsu_out !== 32'h44332211) begin
            tests_failed++;
            $display("FAIL vector_load: got %h want 44332211", v_lsu_out);
        end
    endtask

    task automatic test_vector_store_freeze();
        int dly[VS];
        dly = '{1, 0, 2, 0};
        run_access(1'b0, 1'b1, 1'b1, 8'h80, 8'h00, 32'hDEADBEEF, dly, 1'b1, -1);
    endtask

    task automatic test_read_write_both();
        int dly[VS];
        dly = '{1, 0, 0, 0};
        mem_model[8'h05] = 8'h5A;
        run_access(1'b1, 1'b1, 1'b0, 8'h05, 8'hFF, '0, dly, 1'b0, -1);
    endtask

    task automatic test_no_request();
        @(negedge clk);
        core_state = ST_REQUEST; rd_en = 1'b0; wr_en = 1'b0;
        repeat (2) @(negedge clk);
        core_state = ST_UPDATE; rd_en = 1'b1;
        @(negedge clk);
        tests_run++;
        if (lsu_state !== 2'b00 || mem_bus.mem_read_valid !== 1'b0 || mem_bus.mem_write_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL no_request: state %b rv %b wv %b want 00/0/0",
                     lsu_state, mem_bus.mem_read_valid, mem_bus.mem_write_valid);
        end
        clear_inputs();
    endtask

    task automatic test_reset_mid_vector();
        int dly[VS];
        dly = '{0, 1, 0, 0};
        run_access(1'b1, 1'b0, 1'b1, 8'h40, 8'h00, '0, dly, 1'b0, 2);
        dly = '{0, 0, 0, 0};
        mem_model[8'h77] = 8'hC3;
        run_access(1'b1, 1'b0, 1'b0, 8'h77, 8'h00, '0, dly, 1'b0, -1);
    endtask

`ifdef LSU_TIMEOUT_EN
    task automatic test_timeout();
        @(negedge clk);
        core_state = ST_REQUEST; rd_en = 1'b1; vec_en = 1'b0; rs = 8'h30;
        @(negedge clk);
        core_state = ST_WAIT;
        for (int c = 0; c < TO; c++) begin
            @(negedge clk);
            tests_run++;
            if (mem_bus.mem_read_valid !== 1'b1 || lsu_state !== 2'b10) begin
                tests_failed++;
                $display("FAIL timeout_wait cycle %0d: rv %b state %b want 1/10",
                         c, mem_bus.mem_read_valid, lsu_state);
            end
        end
        @(negedge clk);
        tests_run++;
        if (mem_bus.mem_read_valid !== 1'b0 || lsu_state !== 2'b11 || lsu_error !== 1'b1) begin
            tests_failed++;
            $display("FAIL timeout_fire: rv %b state %b err %b want 0/11/1",
                     mem_bus.mem_read_valid, lsu_state, lsu_error);
        end
        core_state = ST_UPDATE;
        @(negedge clk);
        tests_run++;
        if (lsu_state !== 2'b00 || lsu_error !== 1'b0 || lsu_out !== exp_lsu_out) begin
            tests_failed++;
            $display("FAIL timeout_clear: state %b err %b out %h want 00/0/%h",
                     lsu_state, lsu_error, lsu_out, exp_lsu_out);
        end
        clear_inputs();
    endtask
`else
    task automatic test_long_wait();
        int dly[VS];
        dly = '{300, 0, 0, 0};
        mem_model[8'h30] = 8'h6E;
        run_access(1'b1, 1'b0, 1'b0, 8'h30, 8'h00, '0, dly, 1'b0, -1);
    endtask
`endif

    task automatic test_random();
        int dly[VS];
        logic r, w;
        dly = '{-1, -1, -1, -1};
        for (int t = 0; t < 24; t++) begin
            r = 1'($urandom);
            w = r ? 1'($urandom) : 1'b1;
            run_access(r, w, 1'($urandom), DB'($urandom), DB'($urandom), VS*DB'($urandom),
                       dly, (t % 5) == 0, -1);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem_model[i] = DB'($urandom);
        test_reset();
        test_scalar_load();
        test_scalar_store();
        test_vector_load();
        test_vector_store_freeze();
        test_read_write_both();
        test_no_request();
        test_reset_mid_vector();
`ifdef LSU_TIMEOUT_EN
        test_timeout();
`else
        test_long_wait();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/lsu.md
Name: lsu

Overview:
- Per-thread load/store unit. Consumes the rs/rt operands produced by the thread register file and issues scalar or vector memory transactions to the memory controller.
- Returns load data as lsu_out / v_lsu_out, which the register file writes back in UPDATE when reg_input_mux = MEMORY.
- Sequenced by the core_state broadcast: REQUEST 3'b011, WAIT 3'b100, UPDATE 3'b110.

Parameters:
DATA_BITS, 8, width of one data element and of a memory word
ADDR_BITS, 8, memory address width
VECTOR_SIZE, 4, elements per vector register
TIMEOUT_CYCLES, 255, WAITING-cycle limit (used only with LSU_TIMEOUT_EN)

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
enable  in  1  thread active; low freezes all state and outputs
core_state  in  3  core pipeline state
decoded_mem_read_enable  in  1  LDR instruction
decoded_mem_write_enable  in  1  STR instruction
decoded_vector_mux  in  1  1 = vector access of VECTOR_SIZE elements
rs  in  DATA_BITS  base address (low ADDR_BITS used, zero-extended if narrower)
rt  in  DATA_BITS  scalar store data
v_rt  in  VECTOR_SIZE*DATA_BITS  vector store data, element i at [i*DATA_BITS +: DATA_BITS]
mem_read_valid  out  1  read request
mem_read_address  out  ADDR_BITS  read address
mem_read_ready  in  1  read complete, data valid this cycle
mem_read_data  in  DATA_BITS  read data
mem_write_valid  out  1  write request
mem_write_address  out  ADDR_BITS  write address
mem_write_data  out  DATA_BITS  write data
mem_write_ready  in  1  write accepted
lsu_state  out  2  IDLE 00, REQUESTING 01, WAITING 10, DONE 11
lsu_out  out  DATA_BITS  scalar load result
v_lsu_out  out  VECTOR_SIZE*DATA_BITS  vector load result
lsu_error  out  1  timeout flag (constant 0 without LSU_TIMEOUT_EN)

Behaviour:
- Reset (async, takes effect immediately): lsu_state = IDLE; all mem_* outputs, lsu_out, v_lsu_out, lsu_error and the element index = 0. A request in flight is dropped; valid falls without waiting for a clock edge.
- enable = 0: registers hold, no transitions. A valid request stays asserted and a ready pulse is ignored.
- IDLE: at an edge with core_state = REQUEST and read or write enable set -> REQUESTING, index = 0.
  - Read and write both set: treated as a read; the write is ignored.
  - Neither set: stay IDLE.
- REQUESTING: at the edge, load the address = rs + index (mod 2^ADDR_BITS, wraps with no error) into the active channel, assert its valid, go WAITING.
  - Write data = rt (scalar) or element[index] of v_rt (vector).
- WAITING: valid, address and data are held stable until ready is sampled high at an edge. On that edge:
  - valid <= 0.
  - Read: mem_read_data goes to lsu_out (scalar) or v_lsu_out element[index] (vector).
  - Scalar access, or index = VECTOR_SIZE-1: go DONE.
  - Otherwise index += 1 and go REQUESTING.
  - ready on the inactive channel, or in any other state, is ignored.
- DONE: outputs hold. At an edge with core_state = UPDATE -> IDLE. lsu_out / v_lsu_out keep their value until the next load overwrites them.
- Vector loads: v_lsu_out elements are not cleared at the start of the access; each element updates as it completes.
- Latency: ready returned in the first WAITING cycle gives DONE 3 edges after REQUEST is sampled for a scalar access, and 2*VECTOR_SIZE+1 edges for a vector access.
- At most one of mem_read_valid / mem_write_valid is high at any time.

Optional Feature:
- LSU_TIMEOUT_EN defined: an 8+ bit counter clears on entry to WAITING and increments each enabled WAITING cycle. When it reaches TIMEOUT_CYCLES without ready:
  - valid drops, state goes DONE, lsu_error = 1, the remaining vector elements are abandoned.
  - lsu_error clears on DONE -> IDLE or on reset.
- Undefined: no counter; WAITING persists indefinitely; lsu_error tied 0.

Test Plan:
- Scalar LDR: rs = 0x10, ready at the 2nd WAITING cycle with data 0xA5 -> mem_read_address 0x10, valid high for exactly 2 cycles, lsu_out = 0xA5, DONE held until UPDATE, then IDLE.
- Scalar STR: rs = 0x20, rt = 0x3C -> mem_write_address 0x20, mem_write_data 0x3C stable until ready; read valid never asserts.
- Vector LDR: rs = 0xFE, data 0x11/0x22/0x33/0x44, ready delays 0/2/1/3 -> addresses 0xFE, 0xFF, 0x00, 0x01; v_lsu_out = 0x44332211.
- Read and write both set, rs = 0x05 -> read only at 0x05; mem_write_valid stays 0.
- Reset asserted mid-vector (after element 1) -> valid drops asynchronously, lsu_state = IDLE; a following scalar load completes normally.
- With LSU_TIMEOUT_EN and TIMEOUT_CYCLES = 4, ready never asserted -> valid drops after 4 WAITING cycles, DONE with lsu_error = 1, error cleared after UPDATE.
